// File: rtl/sprdma.sv
`default_nettype none
// ============================================================================
// Module      : sprdma
// Description : Sprite DMA engine. A CPU write to DMA_REG_ADDR copies the
//               256 bytes of the selected CPU page into the PPU OAM data
//               port, three clocks per byte (read address, read capture,
//               OAM write), while the CPU is stalled.
// Revision    : 1.0 - initial release
// ============================================================================
module sprdma #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    input  logic [7:0]  mc_din,
    output logic        active,
    output logic [15:0] mc_addr,
    output logic        mc_wr,
    output logic [7:0]  mc_dout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_ADDR = 2'd1;
    localparam logic [1:0] S_RD_CAP  = 2'd2;
    localparam logic [1:0] S_WR      = 2'd3;

    logic [1:0] state_q, state_d;
    logic [7:0] page_q,  page_d;
    logic [7:0] offset_q, offset_d;
    logic [7:0] byte_q,  byte_d;
    logic       trigger;

    // Trigger only counts in IDLE; stray strobes during a transfer are ignored
    assign trigger = cpu_wr && (cpu_addr == DMA_REG_ADDR);

    // State and datapath registers, cleared asynchronously to abandon a transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            page_q   <= 8'h00;
            offset_q <= 8'h00;
            byte_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            offset_q <= offset_d;
            byte_q   <= byte_d;
        end
    end

    // Next-state and datapath update: read, capture, write, then advance offset
    always_comb begin
        state_d  = state_q;
        page_d   = page_q;
        offset_d = offset_q;
        byte_d   = byte_q;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    page_d   = cpu_dout;
                    offset_d = 8'h00;
                    state_d  = S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                byte_d  = mc_din;
                state_d = S_WR;
            end
            S_WR: begin
                if (offset_q == 8'hFF) begin
                    state_d = S_IDLE;
                end else begin
                    // Offset wraps within the page; the page never increments
                    offset_d = offset_q + 8'd1;
                    state_d  = S_RD_ADDR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registered state, no input-to-output path
    always_comb begin
        active  = (state_q != S_IDLE);
        mc_addr = 16'h0000;
        mc_wr   = 1'b0;
        mc_dout = byte_q;
        case (state_q)
            S_RD_ADDR, S_RD_CAP: begin
                mc_addr = {page_q, offset_q};
            end
            S_WR: begin
                mc_addr = OAM_DATA_ADDR;
                mc_wr   = 1'b1;
            end
            default: begin
                mc_addr = 16'h0000;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_sprdma.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprdma
// Description : Self-checking bench for sprdma with a synchronous memory
//               controller model and a per-transfer reference of the OAM
//               byte stream and read-address sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprdma;

    logic        clk;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  mc_din;
    logic        active;
    logic [15:0] mc_addr;
    logic        mc_wr;
    logic [7:0]  mc_dout;

    int checks;
    int errors;

    logic [7:0]  mem [0:65535];
    logic [15:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [15:0] ra_q[$];
    int          act_cnt;
    int          consec;
    logic        prev_wr;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        exp_active;
    } nt_vec_t;

    typedef struct {
        logic [7:0] page;
        int         retrig;
    } xfer_t;

    nt_vec_t nt_tab[4];
    xfer_t   xt[5];

    sprdma #(
        .DMA_REG_ADDR  (16'h4014),
        .OAM_DATA_ADDR (16'h2004)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_dout (cpu_dout),
        .cpu_wr   (cpu_wr),
        .mc_din   (mc_din),
        .active   (active),
        .mc_addr  (mc_addr),
        .mc_wr    (mc_wr),
        .mc_dout  (mc_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source view of CPU space: the unsupported 0x4000-0x7FFF range reads 0xCD
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        if (a >= 16'h4000 && a < 16'h8000) return 8'hCD;
        return mem[a];
    endfunction

    // Memory controller with one clock of read latency
    always @(posedge clk) mc_din <= src_byte(mc_addr);

    // Bus monitor sampled on the falling edge
    always @(negedge clk) begin
        if (active) act_cnt++;
        if (mc_wr) begin
            wa_q.push_back(mc_addr);
            wd_q.push_back(mc_dout);
            if (prev_wr) consec++;
        end else if (active) begin
            ra_q.push_back(mc_addr);
        end
        prev_wr = mc_wr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        act_cnt = 0;
        consec  = 0;
    endtask

    // Drive a single-cycle CPU write; returns 1 time unit after the sampling edge
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_wr   = 1'b1;
        cpu_addr = a;
        cpu_dout = d;
        @(posedge clk);
        #1;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    task automatic run_transfer(input logic [7:0] page, input int retrig);
        int cnt;
        clear_log();
        cpu_write(16'h4014, page);
        chk($sformatf("active_at_E0 p%02h", page), {31'd0, active}, 32'd1);
        if (retrig != 0) begin
            repeat (retrig - 1) @(posedge clk);
            #1;
            cpu_wr   = 1'b1;
            cpu_addr = 16'h4014;
            cpu_dout = 8'h07;
            @(posedge clk);
            #1;
            cpu_wr   = 1'b0;
            cpu_addr = 16'h0000;
            cpu_dout = 8'h00;
        end
        cnt = 0;
        while (active && cnt < 2000) begin
            @(negedge clk);
            cnt++;
        end
        chk($sformatf("timeout p%02h", page), {31'd0, active}, 32'd0);
        chk($sformatf("active_len p%02h", page), act_cnt, 32'd768);
        chk($sformatf("wr_count p%02h", page), wa_q.size(), 32'd256);
        chk($sformatf("consec_wr p%02h", page), consec, 32'd0);
        if (wa_q.size() == 256) begin
            for (int k = 0; k < 256; k++) begin
                chk($sformatf("oam_addr p%02h k%0d", page, k), wa_q[k], 32'h2004);
                chk($sformatf("oam_data p%02h k%0d", page, k), wd_q[k],
                    {24'd0, src_byte({page, k[7:0]})});
            end
        end
        chk($sformatf("rd_count p%02h", page), ra_q.size(), 32'd512);
        if (ra_q.size() == 512) begin
            for (int k = 0; k < 256; k++) begin
                chk($sformatf("rd_addr0 p%02h k%0d", page, k), ra_q[2*k],   {16'd0, page, k[7:0]});
                chk($sformatf("rd_addr1 p%02h k%0d", page, k), ra_q[2*k+1], {16'd0, page, k[7:0]});
            end
        end
    endtask

    initial begin
        int cnt;
        logic [15:0] ra;
        checks   = 0;
        errors   = 0;
        prev_wr  = 1'b0;
        cpu_wr   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_dout = 8'h00;
        clear_log();

        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int k = 0; k < 256; k++) mem[16'h0200 + k] = 8'(k) ^ 8'h5A;
        // Keep page 0x10 byte 99 nonzero so the async clear of mc_dout is visible
        mem[16'h1063] = 8'hA5;

        nt_tab[0] = '{1'b1, 16'h4015, 8'h02, 1'b0};
        nt_tab[1] = '{1'b1, 16'h4013, 8'h02, 1'b0};
        nt_tab[2] = '{1'b0, 16'h4014, 8'h02, 1'b0};
        nt_tab[3] = '{1'b1, 16'h2004, 8'h33, 1'b0};

        xt[0] = '{8'h02, 0};
        xt[1] = '{8'h03, 100};
        xt[2] = '{8'h50, 0};
        xt[3] = '{8'($urandom_range(0, 255)), 0};
        xt[4] = '{8'($urandom_range(0, 255)), 0};

        // Reset state
        rst_n = 1'b0;
        #3;
        chk("rst_active",  {31'd0, active}, 32'd0);
        chk("rst_mc_addr", {16'd0, mc_addr}, 32'd0);
        chk("rst_mc_wr",   {31'd0, mc_wr}, 32'd0);
        chk("rst_mc_dout", {24'd0, mc_dout}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Writes that must not start a transfer
        for (int i = 0; i < 4; i++) begin
            clear_log();
            @(posedge clk);
            #1;
            cpu_wr   = nt_tab[i].wr;
            cpu_addr = nt_tab[i].addr;
            cpu_dout = nt_tab[i].data;
            @(posedge clk);
            #1;
            cpu_wr   = 1'b0;
            cpu_addr = 16'h0000;
            repeat (3) @(negedge clk);
            chk($sformatf("nt_active %0d", i), {31'd0, active}, {31'd0, nt_tab[i].exp_active});
            chk($sformatf("nt_wr %0d", i), wa_q.size(), 32'd0);
        end

        // Random non-trigger writes
        clear_log();
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom);
            if (ra == 16'h4014) ra = 16'h4016;
            cpu_write(ra, 8'($urandom));
        end
        repeat (2) @(negedge clk);
        chk("rand_nt_active", act_cnt, 32'd0);
        chk("rand_nt_wr", wa_q.size(), 32'd0);

        // Table of full transfers against the reference stream
        for (int i = 0; i < 5; i++) run_transfer(xt[i].page, xt[i].retrig);

        // Reset in the middle of a transfer (cycle 300 = byte 100 read address)
        clear_log();
        cpu_write(16'h4014, 8'h10);
        repeat (300) @(posedge clk);
        #2;
        chk("pre_rst_active", {31'd0, active}, 32'd1);
        chk("pre_rst_mc_addr", {16'd0, mc_addr}, 32'h1064);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_active",  {31'd0, active}, 32'd0);
        chk("mid_rst_mc_wr",   {31'd0, mc_wr}, 32'd0);
        chk("mid_rst_mc_addr", {16'd0, mc_addr}, 32'd0);
        chk("mid_rst_mc_dout", {24'd0, mc_dout}, 32'd0);
        chk("mid_rst_writes_before", wa_q.size(), 32'd100);
        clear_log();
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            cnt++;
        end
        chk("post_rst_active", act_cnt, 32'd0);
        chk("post_rst_writes", wa_q.size(), 32'd0);
        run_transfer(8'h01, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
